// File: rtl/mult_pkg.sv
// Shared types for the multiply/accumulate datapath.
// Holds the accumulator FSM state encoding used by product_accumulator.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Block carry-lookahead adder: 4-bit groups with group generate/propagate,
// carries between groups resolved from the group terms rather than the sum bits.
module carry_lookahead_adder #(
  parameter int DATA_WID = 16
) (
  input  logic [DATA_WID-1:0] i_a,
  input  logic [DATA_WID-1:0] i_b,
  input  logic                carry_in,
  output logic [DATA_WID-1:0] o_sum,
  output logic                carry_out
);

  localparam int N_BLK = (DATA_WID + 3) / 4;

  logic [DATA_WID-1:0] w_g;
  logic [DATA_WID-1:0] w_p;
  logic [N_BLK-1:0]    w_grp_g;
  logic [N_BLK-1:0]    w_grp_p;
  logic [N_BLK-1:0]    w_blk_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  genvar gi;
  generate
    for (gi = 0; gi < N_BLK; gi++) begin : g_blk
      localparam int LO = gi * 4;
      localparam int HI = (gi * 4 + 3 < DATA_WID) ? gi * 4 + 3 : DATA_WID - 1;
      localparam int BW = HI - LO + 1;

      logic [BW-1:0] w_blk_sum;
      logic          w_gg;
      logic          w_gp;
      logic          w_c;

      // Group terms depend only on operands, so they stay out of the carry path.
      always_comb begin
        w_gg = 1'b0;
        w_gp = 1'b1;
        for (int j = 0; j < BW; j++) begin
          w_gg = w_g[LO+j] | (w_p[LO+j] & w_gg);
          w_gp = w_gp & w_p[LO+j];
        end
      end

      always_comb begin
        w_blk_sum = '0;
        w_c = w_blk_c[gi];
        for (int j = 0; j < BW; j++) begin
          w_blk_sum[j] = w_p[LO+j] ^ w_c;
          w_c = w_g[LO+j] | (w_p[LO+j] & w_c);
        end
      end

      assign w_grp_g[gi]  = w_gg;
      assign w_grp_p[gi]  = w_gp;
      assign o_sum[HI:LO] = w_blk_sum;
    end
  endgenerate

  always_comb begin
    carry_out = carry_in;
    w_blk_c = '0;
    for (int k = 0; k < N_BLK; k++) begin
      w_blk_c[k] = carry_out;
      carry_out = w_grp_g[k] | (w_grp_p[k] & carry_out);
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned products into an ACC_WID accumulator with a sticky overflow flag.
// Define PRODUCT_ACC_SATURATE_EN to clamp at all-ones on overflow instead of wrapping.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_WID = 64,
  parameter int ACC_WID  = 72,
  parameter int N_TERMS  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PROD_WID-1:0] product,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_WID-1:0]  acc_out,
  output logic                overflow,
  output logic                busy
);

  localparam int CNT_WID = $clog2(N_TERMS + 1);
  localparam logic [CNT_WID-1:0] LAST_CNT = CNT_WID'(N_TERMS - 1);

  acc_state_t         r_state;
  acc_state_t         w_state_next;
  logic [ACC_WID-1:0] r_acc;
  logic [ACC_WID-1:0] w_addend;
  logic [ACC_WID-1:0] w_sum;
  logic [CNT_WID-1:0] r_cnt;
  logic               r_ovf;
  logic               w_carry;
  logic               w_start;
  logic               w_accept;
  logic               w_last;

  assign w_addend = ACC_WID'(product);
  assign w_start  = (r_state == IDLE) && start;
  assign w_accept = (r_state == ACCUM) && in_valid;
  assign w_last   = (r_cnt == LAST_CNT);

  carry_lookahead_adder #(
    .DATA_WID (ACC_WID)
  ) u_adder (
    .i_a       (r_acc),
    .i_b       (w_addend),
    .carry_in  (1'b0),
    .o_sum     (w_sum),
    .carry_out (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = ACCUM;
      ACCUM:   if (w_accept && w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ACCUM);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNT_WID'(1);
      r_ovf <= r_ovf | w_carry;
`ifdef PRODUCT_ACC_SATURATE_EN
      // Once clamped, later terms must not pull the value off all-ones.
      r_acc <= (r_ovf | w_carry) ? '1 : w_sum;
`else
      r_acc <= w_sum;
`endif
    end
  end

  assign acc_out  = r_acc;
  assign overflow = r_ovf;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter PROD_WID, default 64, meaning width of one incoming product (multicand width + multiplier width).
REQ-002 SHALL have parameter ACC_WID, default 72, meaning accumulator width; ACC_WID >= PROD_WID.
REQ-003 SHALL have parameter N_TERMS, default 8, meaning products summed per accumulation; N_TERMS >= 1.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, meaning begin a new accumulation.
REQ-007 SHALL have port in_valid, input, 1, meaning product is valid.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts a product this cycle.
REQ-009 SHALL have port product, input, PROD_WID, meaning the unsigned product from the upstream multiplier.
REQ-010 SHALL have port out_valid, output, 1, meaning acc_out holds a finished sum.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer takes acc_out.
REQ-012 SHALL have port acc_out, output, ACC_WID, meaning the accumulated sum.
REQ-013 SHALL have port overflow, output, 1, meaning the sum exceeded ACC_WID bits during this accumulation.
REQ-014 SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-016 SHALL go IDLE->ACCUM on start=1 in IDLE; the same edge clears the accumulator, the term counter and overflow.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL drive in_ready=1 only in ACCUM; a product is accepted on any edge with in_valid & in_ready.
REQ-019 SHALL add each accepted product, zero-extended to ACC_WID, on its acceptance edge (one-cycle latency, no bubble), allowing back-to-back acceptance every cycle.
REQ-020 SHALL go ACCUM->DONE on the edge that accepts term N_TERMS; out_valid=1 from the following cycle.
REQ-021 SHALL hold acc_out and overflow stable in DONE until out_valid & out_ready, then return to IDLE on that edge.
REQ-022 SHALL set overflow (sticky) when an addition carries out of ACC_WID.
REQ-023 SHALL leave acc_out as the last sum in IDLE; out_valid=0 outside DONE.
REQ-024 SHALL size the term counter to $clog2(N_TERMS+1) bits; it does not wrap.

Reset
REQ-025 SHALL, when rst=1 at an edge in any state (including mid-accumulation), enter IDLE, zero the accumulator and counter, and clear overflow; any pending sum is discarded.
REQ-026 SHALL, after reset, drive in_ready=0, out_valid=0, acc_out=0, overflow=0 and busy=0.
REQ-027 SHALL give rst priority over start and all handshakes.

Configuration
REQ-028 SHALL, with PRODUCT_ACC_SATURATE_EN defined, clamp the accumulator to all-ones on overflow and keep it there for the rest of the accumulation.
REQ-029 SHALL, without PRODUCT_ACC_SATURATE_EN, wrap the accumulator modulo 2^ACC_WID; overflow is flagged in both builds.

Structure
REQ-030 SHALL place the state enum type (acc_state_t) in the shared package mult_pkg.
REQ-031 SHALL perform the addition through one instance of the team's carry_lookahead_adder with DATA_WID=ACC_WID and carry_in=0; its carry_out feeds overflow.

Verification (PROD_WID=8, N_TERMS=4)
REQ-032 SHALL pass with ACC_WID=10: start, then products 225,225,225,225 on consecutive cycles -> out_valid 5 cycles after start, acc_out=900, overflow=0.
REQ-033 SHALL pass with ACC_WID=9 and the same stimulus -> overflow=1; acc_out=388 (wrap) or 511 (PRODUCT_ACC_SATURATE_EN).
REQ-034 SHALL pass with gaps in in_valid and products 1,2,3,4 -> acc_out=10; in_ready stays 1 only in ACCUM.
REQ-035 SHALL pass with out_ready held 0 for 3 cycles in DONE -> acc_out=10 and out_valid stay stable; a start during DONE is ignored; return to IDLE on the out_ready edge.
REQ-036 SHALL pass with rst pulsed after 2 accepted terms -> next cycle IDLE, acc_out=0, busy=0; a new start followed by 5,5,5,5 gives 20.
